decode_hazard_unit: RTL

Registered instruction-decode stage for the 16-bit core, successor to the combinational control decoder. It extracts source and destination registers from each fetched instruction. A parametrised scoreboard tracks pending register writes across the downstream stages and stalls fetch on a read-after-write hazard. It also handles branch flush and HALT draining, and drives the ID/EX register fields consumed by execute.

---
 rtl/decode_hazard_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: registered ID stage with a pending-write scoreboard,
// RAW stall, branch flush and HALT drain for the 16-bit core.
module decode_hazard_unit #(
    parameter int TRACK_DEPTH = 3,
    parameter int FWD_EN      = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [15:0]            if_instr,
    output logic                   if_ready,
    input  logic                   flush,
    output logic                   id_valid,
    output logic [15:0]            id_instr,
    output logic [2:0]             id_rs,
    output logic [2:0]             id_rt,
    output logic [2:0]             id_rd,
    output logic                   id_regwrt,
    output logic                   id_memread,
    output logic                   halt_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    state_e                      state_q;
    logic [TRACK_DEPTH-1:0]      sb_v_q;
    logic [TRACK_DEPTH-1:0]      sb_ld_q;
    logic [TRACK_DEPTH-1:0][2:0] sb_rd_q;

    logic                   id_valid_q;
    logic [15:0]            id_instr_q;
    logic [2:0]             id_rs_q;
    logic [2:0]             id_rt_q;
    logic [2:0]             id_rd_q;
    logic                   id_regwrt_q;
    logic                   id_memread_q;
    logic                   halt_done_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [4:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;

    logic is_i1, is_r, is_st, is_ld, is_stu, is_btr;
    logic is_br, is_lbi, is_slbi, is_jr, is_jal, is_jalr;
    logic is_halt;
    logic wr_en, use_rs, use_rt;
    logic hazard, run, issue, stall;

    assign op = if_instr[15:11];
    assign rs = if_instr[10:8];
    assign rt = if_instr[7:5];

    assign is_i1   = (op[4:2] == 3'b010) || (op[4:2] == 3'b101);
    assign is_r    = (op[4:1] == 4'b1101) || (op[4:2] == 3'b111);
    assign is_st   = (op == 5'b10000);
    assign is_ld   = (op == 5'b10001);
    assign is_stu  = (op == 5'b10011);
    assign is_btr  = (op == 5'b11001);
    assign is_br   = (op[4:2] == 3'b011);
    assign is_lbi  = (op == 5'b11000);
    assign is_slbi = (op == 5'b10010);
    assign is_jr   = (op == 5'b00101);
    assign is_jal  = (op == 5'b00110);
    assign is_jalr = (op == 5'b00111);
    assign is_halt = (op == 5'b00000);

    assign wr_en = is_i1 | is_r | is_ld | is_stu | is_btr
                 | is_lbi | is_slbi | is_jal | is_jalr;
    assign use_rs = is_i1 | is_r | is_st | is_ld | is_stu | is_btr
                  | is_br | is_slbi | is_jr | is_jalr;
    assign use_rt = is_r | is_st | is_stu;

    always_comb begin
        rd = if_instr[4:2];
        unique case (1'b1)
            is_r:                    rd = if_instr[4:2];
            is_i1, is_ld:            rd = if_instr[7:5];
            is_lbi, is_slbi, is_stu: rd = if_instr[10:8];
            is_jal, is_jalr:         rd = 3'd7;
            default:                 rd = if_instr[4:2];
        endcase
    end

    // With forwarding only a load sitting in ID/EX can't be bypassed.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < TRACK_DEPTH; i++) begin
            if (sb_v_q[i] &&
                ((use_rs && sb_rd_q[i] == rs) ||
                 (use_rt && sb_rd_q[i] == rt))) begin
                if (FWD_EN == 0 || (i == 0 && sb_ld_q[i]))
                    hazard = 1'b1;
            end
        end
        hazard = hazard && if_valid;
    end

    assign run   = (state_q == RUN);
    assign issue = if_valid && run && !flush && !hazard;
    assign stall = hazard && run && !flush;

    always_comb begin
        if (rst)
            if_ready = 1'b0;
        else if (flush)
            if_ready = 1'b1;
        else if (!run)
            if_ready = 1'b0;
        else
            if_ready = !hazard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            sb_v_q       <= '0;
            sb_ld_q      <= '0;
            sb_rd_q      <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP;
            id_rs_q      <= '0;
            id_rt_q      <= '0;
            id_rd_q      <= '0;
            id_regwrt_q  <= 1'b0;
            id_memread_q <= 1'b0;
            halt_done_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            sb_v_q[0]  <= issue && wr_en;
            sb_rd_q[0] <= rd;
            sb_ld_q[0] <= is_ld;
            for (int i = 1; i < TRACK_DEPTH; i++) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
                sb_ld_q[i] <= sb_ld_q[i-1];
            end

            if (issue) begin
                id_valid_q   <= 1'b1;
                id_instr_q   <= if_instr;
                id_rs_q      <= rs;
                id_rt_q      <= rt;
                id_rd_q      <= rd;
                id_regwrt_q  <= wr_en;
                id_memread_q <= is_ld;
            end else begin
                id_valid_q   <= 1'b0;
                id_instr_q   <= NOP;
                id_rs_q      <= '0;
                id_rt_q      <= '0;
                id_rd_q      <= '0;
                id_regwrt_q  <= 1'b0;
                id_memread_q <= 1'b0;
            end

            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);

            halt_done_q <= (state_q == HALTED);

            case (state_q)
                RUN:
                    if (issue && is_halt)
                        state_q <= DRAIN;
                DRAIN:
                    if (sb_v_q == '0 && !id_valid_q)
                        state_q <= HALTED;
                default: ;
            endcase
        end
    end

    assign id_valid   = id_valid_q;
    assign id_instr   = id_instr_q;
    assign id_rs      = id_rs_q;
    assign id_rt      = id_rt_q;
    assign id_rd      = id_rd_q;
    assign id_regwrt  = id_regwrt_q;
    assign id_memread = id_memread_q;
    assign halt_done  = halt_done_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
